pong_game_engine: RTL and testbench

//  Game-state stage directly upstream of the frame renderer: owns ball position/direction,

---
 rtl/pong_pkg.sv | 43 ++++
 rtl/pong_game_engine_if.sv | 24 ++
 rtl/pong_paddle_ctrl.sv | 35 +++
 rtl/pong_game_engine.sv | 182 ++++++++++++++++++
 tb/tb_pong_game_engine.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared geometry, derived constants and game state encoding
package pong_pkg;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int BALL_SIZE    = 10;
  localparam int PADDLE_W     = 10;
  localparam int PADDLE_H     = 60;
  localparam int PADDLEL_X    = 3;
  localparam int PADDLER_X    = 630;
  localparam int PADDLE_STEP  = 4;
  localparam int BALL_SPEED   = 2;
  localparam int WIN_SCORE    = 7;
  localparam int SERVE_FRAMES = 60;

  // Ball rest position (centre of the field, top-left corner of the ball)
  localparam logic [9:0] BALL_X0 = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y0 = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0] PADDLE_Y0 = 10'((SCREEN_H - PADDLE_H) / 2);

  localparam logic [9:0] PADDLE_STEP_V = 10'(PADDLE_STEP);
  localparam logic [9:0] PADDLE_Y_MAX  = 10'(SCREEN_H - PADDLE_H);

  // Ball motion is evaluated in 11-bit signed so that steps past 0 stay negative
  localparam logic signed [10:0] BALL_STEP   = 11'(BALL_SPEED);
  localparam logic signed [10:0] BALL_Y_MAX  = 11'(SCREEN_H - BALL_SIZE);
  localparam logic signed [10:0] LEFT_HIT_X  = 11'(PADDLEL_X + PADDLE_W);
  localparam logic signed [10:0] RIGHT_HIT_X = 11'(PADDLER_X - BALL_SIZE);
  localparam logic signed [10:0] MISS_R_X    = 11'(PADDLER_X);

  localparam logic [10:0] BALL_SIZE_W = 11'(BALL_SIZE);
  localparam logic [10:0] PADDLE_H_W  = 11'(PADDLE_H);

  localparam logic [2:0] WIN_SCORE_V = 3'(WIN_SCORE);
  localparam logic [5:0] SERVE_LAST  = 6'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_e;

endpackage

// File: rtl/pong_game_engine_if.sv
// rtl/pong_game_engine_if.sv - game state bundle from engine to renderer
//   master: engine drives ball/paddle positions, scores and win flags
//   slave : renderer samples them
interface pong_game_engine_if;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] paddleL_y;
  logic [9:0] paddleR_y;
  logic [2:0] scoreL;
  logic [2:0] scoreR;
  logic       game_over;
  logic       left_win;
  logic       right_win;

  modport master (
    output ball_x, ball_y, paddleL_y, paddleR_y, scoreL, scoreR,
           game_over, left_win, right_win
  );

  modport slave (
    input ball_x, ball_y, paddleL_y, paddleR_y, scoreL, scoreR,
          game_over, left_win, right_win
  );
endinterface

// File: rtl/pong_paddle_ctrl.sv
// rtl/pong_paddle_ctrl.sv - paddle position register with step and clamp
//   clk, rst_n : clock, async active-low reset
//   en         : one-cycle update strobe (frame tick while not game over)
//   up, dn     : button levels; both or neither hold position
//   y          : paddle top edge, clamped to [0, SCREEN_H-PADDLE_H]
module pong_paddle_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       dn,
  output logic [9:0] y
);

  logic [9:0] y_q, y_d;

  always_comb begin
    y_d = y_q;
    if (en && up && !dn) begin
      y_d = (y_q < PADDLE_STEP_V) ? 10'd0 : y_q - PADDLE_STEP_V;
    end else if (en && dn && !up) begin
      y_d = (y_q > PADDLE_Y_MAX - PADDLE_STEP_V) ? PADDLE_Y_MAX : y_q + PADDLE_STEP_V;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= PADDLE_Y0;
    else        y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: rtl/pong_game_engine.sv
// rtl/pong_game_engine.sv - per-frame pong game state: ball, paddles, scores, win flags
//   clk, rst_n        : clock, async active-low reset
//   frame_tick        : one-cycle pulse per frame; the only cycle state may change
//   btnL_*/btnR_*     : paddle button levels
//   restart           : starts a new match when sampled on a tick in game over
//   game (master)     : registered game state towards the renderer
module pong_game_engine
  import pong_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic btnL_up,
  input  logic btnL_dn,
  input  logic btnR_up,
  input  logic btnR_dn,
  input  logic restart,
  pong_game_engine_if.master game
);

  state_e     state_q, state_d;
  logic [5:0] serve_cnt_q, serve_cnt_d;
  logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 1 = moving towards larger coordinate
  logic [2:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic       game_over_q, game_over_d, left_win_q, left_win_d, right_win_q, right_win_d;

  logic       paddle_en;
  logic [9:0] paddle_l_y, paddle_r_y;

  assign paddle_en = frame_tick && (state_q != ST_OVER);

  pong_paddle_ctrl u_paddle_l (
    .clk(clk), .rst_n(rst_n), .en(paddle_en), .up(btnL_up), .dn(btnL_dn), .y(paddle_l_y)
  );

  pong_paddle_ctrl u_paddle_r (
    .clk(clk), .rst_n(rst_n), .en(paddle_en), .up(btnR_up), .dn(btnR_dn), .y(paddle_r_y)
  );

  logic signed [10:0] next_x, next_y;
  logic [10:0]        ball_y_w;
  logic               overlap_l, overlap_r, hit_l, hit_r;
  logic               point;

  assign next_x   = $signed({1'b0, ball_x_q}) + (dir_x_q ? BALL_STEP : -BALL_STEP);
  assign next_y   = $signed({1'b0, ball_y_q}) + (dir_y_q ? BALL_STEP : -BALL_STEP);
  assign ball_y_w = {1'b0, ball_y_q};

  // Overlap uses paddle positions from before this frame's paddle move
  assign overlap_l = (ball_y_w + BALL_SIZE_W > {1'b0, paddle_l_y}) &&
                     (ball_y_w < {1'b0, paddle_l_y} + PADDLE_H_W);
  assign overlap_r = (ball_y_w + BALL_SIZE_W > {1'b0, paddle_r_y}) &&
                     (ball_y_w < {1'b0, paddle_r_y} + PADDLE_H_W);
  assign hit_l = !dir_x_q && (next_x <= LEFT_HIT_X) && overlap_l;
  assign hit_r =  dir_x_q && (next_x >= RIGHT_HIT_X) && overlap_r;

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    game_over_d = game_over_q;
    left_win_d  = left_win_q;
    right_win_d = right_win_q;
    point       = 1'b0;

    if (frame_tick) begin
      case (state_q)
        ST_SERVE: begin
          if (serve_cnt_q == SERVE_LAST) state_d = ST_PLAY;
          else                           serve_cnt_d = serve_cnt_q + 6'd1;
        end

        ST_PLAY: begin
          if (next_y <= 11'sd0) begin
            ball_y_d = 10'd0;
            dir_y_d  = 1'b1;
          end else if (next_y >= BALL_Y_MAX) begin
            ball_y_d = BALL_Y_MAX[9:0];
            dir_y_d  = 1'b0;
          end else begin
            ball_y_d = next_y[9:0];
          end

          // Paddle hits are tested before misses so an edge-grazing return still counts
          if (hit_l) begin
            ball_x_d = LEFT_HIT_X[9:0];
            dir_x_d  = 1'b1;
          end else if (hit_r) begin
            ball_x_d = RIGHT_HIT_X[9:0];
            dir_x_d  = 1'b0;
          end else if (next_x <= 11'sd0) begin
            score_r_d = score_r_q + 3'd1;
            dir_x_d   = 1'b0;
            point     = 1'b1;
          end else if (next_x >= MISS_R_X) begin
            score_l_d = score_l_q + 3'd1;
            dir_x_d   = 1'b1;
            point     = 1'b1;
          end else begin
            ball_x_d = next_x[9:0];
          end

          if (point) begin
            ball_x_d    = BALL_X0;
            ball_y_d    = BALL_Y0;
            serve_cnt_d = 6'd0;
            if (score_l_d == WIN_SCORE_V || score_r_d == WIN_SCORE_V) begin
              state_d     = ST_OVER;
              game_over_d = 1'b1;
              left_win_d  = (score_l_d == WIN_SCORE_V);
              right_win_d = (score_r_d == WIN_SCORE_V);
            end else begin
              state_d = ST_SERVE;
            end
          end
        end

        ST_OVER: begin
          if (restart) begin
            state_d     = ST_SERVE;
            serve_cnt_d = 6'd0;
            ball_x_d    = BALL_X0;
            ball_y_d    = BALL_Y0;
            dir_x_d     = 1'b1;
            score_l_d   = 3'd0;
            score_r_d   = 3'd0;
            game_over_d = 1'b0;
            left_win_d  = 1'b0;
            right_win_d = 1'b0;
          end
        end

        default: state_d = ST_SERVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SERVE;
      serve_cnt_q <= 6'd0;
      ball_x_q    <= BALL_X0;
      ball_y_q    <= BALL_Y0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      score_l_q   <= 3'd0;
      score_r_q   <= 3'd0;
      game_over_q <= 1'b0;
      left_win_q  <= 1'b0;
      right_win_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      game_over_q <= game_over_d;
      left_win_q  <= left_win_d;
      right_win_q <= right_win_d;
    end
  end

  assign game.ball_x    = ball_x_q;
  assign game.ball_y    = ball_y_q;
  assign game.paddleL_y = paddle_l_y;
  assign game.paddleR_y = paddle_r_y;
  assign game.scoreL    = score_l_q;
  assign game.scoreR    = score_r_q;
  assign game.game_over = game_over_q;
  assign game.left_win  = left_win_q;
  assign game.right_win = right_win_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// tb/tb_pong_game_engine.sv - self-checking bench for pong_game_engine
module tb_pong_game_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic btnL_up = 1'b0, btnL_dn = 1'b0, btnR_up = 1'b0, btnR_dn = 1'b0;
  logic restart = 1'b0;

  pong_game_engine_if game ();

  pong_game_engine dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btnL_up(btnL_up), .btnL_dn(btnL_dn), .btnR_up(btnR_up), .btnR_dn(btnR_dn),
    .restart(restart), .game(game)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  localparam int M_SERVE = 0, M_PLAY = 1, M_OVER = 2;

  // Reference model of the game, in plain integers
  int m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_cnt, m_mode;
  bit m_go, m_lw, m_rw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bx = 315; m_by = 235; m_dx = 1; m_dy = 1; m_pl = 210; m_pr = 210;
    m_sl = 0; m_sr = 0; m_cnt = 0; m_mode = M_SERVE; m_go = 0; m_lw = 0; m_rw = 0;
  endtask

  function automatic int pad_move(input int y, input bit u, input bit d);
    int r;
    r = y;
    if (u && !d) r = y - 4;
    if (d && !u) r = y + 4;
    if (r < 0) r = 0;
    if (r > 420) r = 420;
    return r;
  endfunction

  function automatic bit covers(input int by, input int py);
    return (by + 10 > py) && (by < py + 60);
  endfunction

  task automatic model_tick(input bit lu, input bit ld, input bit ru, input bit rd, input bit rs);
    int opl, opr, nx, ny;
    bit scored;
    opl = m_pl; opr = m_pr; scored = 0;
    if (m_mode != M_OVER) begin
      m_pl = pad_move(m_pl, lu, ld);
      m_pr = pad_move(m_pr, ru, rd);
    end
    if (m_mode == M_SERVE) begin
      if (m_cnt == 59) m_mode = M_PLAY;
      else m_cnt++;
    end else if (m_mode == M_PLAY) begin
      nx = m_bx + 2 * m_dx;
      ny = m_by + 2 * m_dy;
      if (ny <= 0) begin m_dy = 1; ny = 0; end
      else if (ny >= 470) begin m_dy = -1; ny = 470; end
      if (m_dx < 0 && nx <= 13 && covers(m_by, opl)) begin m_bx = 13; m_dx = 1; end
      else if (m_dx > 0 && nx + 10 >= 630 && covers(m_by, opr)) begin m_bx = 620; m_dx = -1; end
      else if (nx <= 0) begin m_sr++; m_dx = -1; scored = 1; end
      else if (nx >= 630) begin m_sl++; m_dx = 1; scored = 1; end
      else m_bx = nx;
      m_by = ny;
      if (scored) begin
        m_bx = 315; m_by = 235; m_cnt = 0;
        if (m_sl == 7 || m_sr == 7) begin
          m_mode = M_OVER; m_go = 1; m_lw = (m_sl == 7); m_rw = (m_sr == 7);
        end else m_mode = M_SERVE;
      end
    end else if (rs) begin
      m_sl = 0; m_sr = 0; m_go = 0; m_lw = 0; m_rw = 0;
      m_bx = 315; m_by = 235; m_dx = 1; m_cnt = 0; m_mode = M_SERVE;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ball_x"},    32'(game.ball_x),    32'(m_bx));
    chk({tag, ".ball_y"},    32'(game.ball_y),    32'(m_by));
    chk({tag, ".paddleL_y"}, 32'(game.paddleL_y), 32'(m_pl));
    chk({tag, ".paddleR_y"}, 32'(game.paddleR_y), 32'(m_pr));
    chk({tag, ".scoreL"},    32'(game.scoreL),    32'(m_sl));
    chk({tag, ".scoreR"},    32'(game.scoreR),    32'(m_sr));
    chk({tag, ".game_over"}, 32'(game.game_over), 32'(m_go));
    chk({tag, ".left_win"},  32'(game.left_win),  32'(m_lw));
    chk({tag, ".right_win"}, 32'(game.right_win), 32'(m_rw));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".ball_x"},    32'(game.ball_x),    32'd315);
    chk({tag, ".ball_y"},    32'(game.ball_y),    32'd235);
    chk({tag, ".paddleL_y"}, 32'(game.paddleL_y), 32'd210);
    chk({tag, ".paddleR_y"}, 32'(game.paddleR_y), 32'd210);
    chk({tag, ".scoreL"},    32'(game.scoreL),    32'd0);
    chk({tag, ".scoreR"},    32'(game.scoreR),    32'd0);
    chk({tag, ".game_over"}, 32'(game.game_over), 32'd0);
    chk({tag, ".left_win"},  32'(game.left_win),  32'd0);
    chk({tag, ".right_win"}, 32'(game.right_win), 32'd0);
  endtask

  // One frame: tick high for one cycle, compare after the edge, then one idle cycle
  task automatic tick(input bit lu, input bit ld, input bit ru, input bit rd, input bit rs);
    @(negedge clk);
    btnL_up = lu; btnL_dn = ld; btnR_up = ru; btnR_dn = rd; restart = rs;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_tick(lu, ld, ru, rd, rs);
    check_model("frame");
    @(negedge clk);
  endtask

  function automatic void track(input int p, input int target, output bit u, output bit d);
    u = (p > target + 2);
    d = (p < target - 2);
  endfunction

  initial begin
    bit lu, ld, ru, rd, rs;
    int target;

    // Reset state, during and after reset before any tick
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("post_reset");

    // Serve: left up held, right both held; ball stays centred for 60 ticks
    for (int k = 1; k <= 60; k++) begin
      tick(1, 0, 1, 1, 0);
      chk("serve.paddleL_y", 32'(game.paddleL_y), 32'((210 - 4 * k) < 0 ? 0 : 210 - 4 * k));
      chk("serve.paddleR_y", 32'(game.paddleR_y), 32'd210);
      chk("serve.ball_x", 32'(game.ball_x), 32'd315);
      chk("serve.ball_y", 32'(game.ball_y), 32'd235);
    end

    // Now in play: first move is +2,+2
    tick(0, 0, 0, 0, 0);
    chk("launch.ball_x", 32'(game.ball_x), 32'd317);
    chk("launch.ball_y", 32'(game.ball_y), 32'd237);

    // Left tracks the ball, right runs away from it: left wins the match
    for (int i = 0; i < 9000 && m_mode != M_OVER; i++) begin
      track(m_pl, m_by - 25, lu, ld);
      target = (m_by < 240) ? 420 : 0;
      track(m_pr, target, ru, rd);
      tick(lu, ld, ru, rd, 0);
    end
    chk("win.game_over", 32'(game.game_over), 32'd1);
    chk("win.left_win",  32'(game.left_win),  32'd1);
    chk("win.right_win", 32'(game.right_win), 32'd0);
    chk("win.scoreL",    32'(game.scoreL),    32'd7);

    // Game over: everything frozen regardless of buttons
    for (int i = 0; i < 20; i++) begin
      tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
      chk("over.ball_x", 32'(game.ball_x), 32'd315);
      chk("over.scoreL", 32'(game.scoreL), 32'd7);
    end
    tick(0, 0, 0, 0, 1);
    chk("restart.scoreL",    32'(game.scoreL),    32'd0);
    chk("restart.scoreR",    32'(game.scoreR),    32'd0);
    chk("restart.game_over", 32'(game.game_over), 32'd0);
    chk("restart.left_win",  32'(game.left_win),  32'd0);

    // Randomised play against the model
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 9) < 6) track(m_pl, m_by - 25, lu, ld);
      else begin lu = 1'($urandom); ld = 1'($urandom); end
      if ($urandom_range(0, 9) < 4) track(m_pr, m_by - 25, ru, rd);
      else begin ru = 1'($urandom); rd = 1'($urandom); end
      rs = ($urandom_range(0, 3) == 0);
      tick(lu, ld, ru, rd, rs);
    end

    // Get into play, then assert reset between ticks
    for (int i = 0; i < 400 && m_mode != M_PLAY; i++) tick(0, 0, 0, 0, 1);
    tick(0, 1, 1, 0, 0);
    chk("pre_reset.in_play", 32'(m_mode), 32'(M_PLAY));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
